// File: rtl/ard_bus_responder.sv
// ard_bus_responder: memory-side peer of the cpu_core 8-bit byte bus.
// Word-addressed 16-bit memory; fetch/load bytes go back on in_bus, stores arrive as MAR/MDR bytes.
module ard_bus_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned LOAD_WAIT   = 2,
   parameter int unsigned FETCH_WORDS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] out_bus,
   input  logic       bus_pc,
   input  logic       bus_mar,
   input  logic       bus_mdr,
   input  logic       halt,
   output logic [7:0] in_bus,
   output logic       ard_data_ready,
   output logic       ard_receive_ready,
   output logic       error
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(2 * FETCH_WORDS + 1);
   localparam int unsigned WAIT_W = $clog2(LOAD_WAIT + 1);

   typedef enum logic [2:0] {
      IDLE, RX_PC, RX_MAR, ADDR_HELD, RX_MDR, WRITE, TX
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          hi_q, hi_d;
   logic [ADDR_W-1:0]   mar_q, mar_d, base_q, base_d;
   logic [15:0]         data_q, data_d;
   logic [CNT_W-1:0]    tx_idx_q, tx_idx_d, tx_last_q, tx_last_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [7:0]          in_bus_d;
   logic                data_ready_d, receive_ready_d, error_d;

   logic [15:0]         mem [DEPTH];

   logic [1:0]          flag_cnt;
   logic                any_flag, take;
   logic [ADDR_W-1:0]   rx_addr, tx_addr;
   logic [15:0]         rx_word, tx_word, ld_word;

   assign flag_cnt = 2'(bus_pc) + 2'(bus_mar) + 2'(bus_mdr);
   assign any_flag = (flag_cnt != 2'd0);
   assign take     = ard_receive_ready && (flag_cnt == 2'd1);
   assign rx_addr  = ADDR_W'({hi_q, out_bus});
   assign tx_addr  = base_q + ADDR_W'(tx_idx_q >> 1);
   assign rx_word  = mem[rx_addr];
   assign tx_word  = mem[tx_addr];
   assign ld_word  = mem[mar_q];

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      mar_d        = mar_q;
      base_d       = base_q;
      data_d       = data_q;
      tx_idx_d     = tx_idx_q;
      tx_last_d    = tx_last_q;
      wait_d       = wait_q;
      in_bus_d     = in_bus;
      data_ready_d = ard_data_ready;
      error_d      = error;

      if ((flag_cnt > 2'd1) || (any_flag && !ard_receive_ready)) error_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (take && !halt) begin
               hi_d = out_bus;
               if (bus_pc)       state_d = RX_PC;
               else if (bus_mar) state_d = RX_MAR;
               else              error_d = 1'b1;
            end
         end
         RX_PC: begin
            if (halt) state_d = IDLE;
            else if (take) begin
               if (bus_pc) begin
                  base_d       = rx_addr;
                  in_bus_d     = rx_word[15:8];
                  data_ready_d = 1'b1;
                  tx_idx_d     = CNT_W'(1);
                  tx_last_d    = CNT_W'(2 * FETCH_WORDS);
                  state_d      = TX;
               end else begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         RX_MAR: begin
            if (halt) state_d = IDLE;
            else if (take) begin
               if (bus_mar) begin
                  mar_d   = rx_addr;
                  wait_d  = '0;
                  state_d = ADDR_HELD;
               end else begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         ADDR_HELD: begin
            if (halt) state_d = IDLE;
            else if (take) begin
               wait_d         = '0;
               hi_d           = out_bus;
               data_d[15:8]   = out_bus;
               if (bus_mdr)     state_d = RX_MDR;
               else if (bus_pc) state_d = RX_PC;
               else             state_d = RX_MAR;
            end else if (any_flag) begin
               wait_d = '0;
            end else if (wait_q == WAIT_W'(LOAD_WAIT - 1)) begin
               // quiet bus after the address means the core wants a load
               base_d       = mar_q;
               in_bus_d     = ld_word[15:8];
               data_ready_d = 1'b1;
               tx_idx_d     = CNT_W'(1);
               tx_last_d    = CNT_W'(2);
               state_d      = TX;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         RX_MDR: begin
            if (halt) state_d = IDLE;
            else if (take) begin
               if (bus_mdr) begin
                  data_d[7:0] = out_bus;
                  state_d     = WRITE;
               end else begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WRITE: state_d = IDLE;
         TX: begin
            if (tx_idx_q == tx_last_q) begin
               data_ready_d = 1'b0;
               in_bus_d     = '0;
               state_d      = IDLE;
            end else begin
               in_bus_d = tx_idx_q[0] ? tx_word[7:0] : tx_word[15:8];
               tx_idx_d = tx_idx_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      receive_ready_d = !halt && (state_d inside {IDLE, RX_PC, RX_MAR, ADDR_HELD, RX_MDR});
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q           <= IDLE;
         hi_q              <= '0;
         mar_q             <= '0;
         base_q            <= '0;
         data_q            <= '0;
         tx_idx_q          <= '0;
         tx_last_q         <= '0;
         wait_q            <= '0;
         in_bus            <= '0;
         ard_data_ready    <= 1'b0;
         ard_receive_ready <= 1'b1;
         error             <= 1'b0;
      end else begin
         state_q           <= state_d;
         hi_q              <= hi_d;
         mar_q             <= mar_d;
         base_q            <= base_d;
         data_q            <= data_d;
         tx_idx_q          <= tx_idx_d;
         tx_last_q         <= tx_last_d;
         wait_q            <= wait_d;
         in_bus            <= in_bus_d;
         ard_data_ready    <= data_ready_d;
         ard_receive_ready <= receive_ready_d;
         error             <= error_d;
      end
   end

   // Memory contents survive reset; a write lands only on the WRITE cycle
   always_ff @(posedge clk) begin
      if (state_q == WRITE) mem[mar_q] <= data_q;
   end
endmodule
